// File: rtl/csi_pckthandler_vc_if.sv
// Stream bundle between the lane/ECC front end and the CSI-2 packet handler.
// The master side drives the merged beats and headers; the slave side returns pixel payload and status.
interface csi_pckthandler_vc_if #(
    parameter int DATA_STREAM_WIDTH = 16,
    parameter int PH_STREAM_WIDTH   = 24,
    parameter int LINE_CNT_WIDTH    = 12,
    parameter int FRAME_CNT_WIDTH   = 16
);
    localparam int BYTES = DATA_STREAM_WIDTH / 8;

    logic [DATA_STREAM_WIDTH-1:0] data_stream;
    logic [PH_STREAM_WIDTH-1:0]   ph_stream;
    logic                         ph_select;
    logic                         valid_stream;
    logic                         ecc_error;

    logic [DATA_STREAM_WIDTH-1:0] out_stream;
    logic [BYTES-1:0]             out_byte_en;
    logic                         frame_active;
    logic                         frame_valid;
    logic                         sol;
    logic                         eol;
    logic [LINE_CNT_WIDTH-1:0]    line_count;
    logic [FRAME_CNT_WIDTH-1:0]   frame_count;
    logic                         err_ecc;
    logic                         err_trunc;

    modport master (
        output data_stream, ph_stream, ph_select, valid_stream, ecc_error,
        input  out_stream, out_byte_en, frame_active, frame_valid, sol, eol,
               line_count, frame_count, err_ecc, err_trunc
    );

    modport slave (
        input  data_stream, ph_stream, ph_select, valid_stream, ecc_error,
        output out_stream, out_byte_en, frame_active, frame_valid, sol, eol,
               line_count, frame_count, err_ecc, err_trunc
    );
endinterface

// File: rtl/csi_pckthandler_vc.sv
// CSI-2 packet handler: virtual channel / data type filter with frame and line tracking.
// Payload is re-registered with byte enables covering a word count that is not a multiple of the beat width.
module csi_pckthandler_vc #(
    parameter int         DATA_STREAM_WIDTH = 16,
    parameter int         PH_STREAM_WIDTH   = 24,
    parameter logic [5:0] PX_DATA_TYPE      = 6'h2B,
    parameter logic [1:0] VC_SEL            = 2'd0,
    parameter int         LINE_CNT_WIDTH    = 12,
    parameter int         FRAME_CNT_WIDTH   = 16
) (
    input logic               rxbyteclkhs,
    input logic               reset,
    csi_pckthandler_vc_if.slave bus
);
    localparam int          BYTES    = DATA_STREAM_WIDTH / 8;
    localparam logic [15:0] BYTES_WC = 16'(BYTES);
    localparam logic [5:0]  DT_FS    = 6'h00;
    localparam logic [5:0]  DT_FE    = 6'h01;

    typedef enum logic [1:0] {
        PH_DECODE = 2'd0,
        REC_DATA  = 2'd1,
        WAIT_EOT  = 2'd2
    } state_t;

    state_t                       state_reg, state_next;
    logic [15:0]                  remaining_reg, remaining_next;
    logic                         first_beat_reg, first_beat_next;
    logic [DATA_STREAM_WIDTH-1:0] out_stream_reg, out_stream_next;
    logic [BYTES-1:0]             out_byte_en_reg, out_byte_en_next;
    logic                         frame_valid_reg, frame_valid_next;
    logic                         sol_reg, sol_next;
    logic                         eol_reg, eol_next;
    logic                         frame_active_reg, frame_active_next;
    logic [LINE_CNT_WIDTH-1:0]    line_count_reg, line_count_next;
    logic [FRAME_CNT_WIDTH-1:0]   frame_count_reg, frame_count_next;
    logic                         err_ecc_reg, err_ecc_next;
    logic                         err_trunc_reg, err_trunc_next;

    logic [15:0] ph_wc;
    logic [1:0]  ph_vc;
    logic [5:0]  ph_dt;
    logic        hdr_valid;
    logic        hdr_accept;
    logic        last_beat;
    logic [BYTES-1:0] beat_byte_en;

    assign ph_wc      = bus.ph_stream[23:8];
    assign ph_vc      = bus.ph_stream[7:6];
    assign ph_dt      = bus.ph_stream[5:0];
    assign hdr_valid  = bus.valid_stream & bus.ph_select;
    assign hdr_accept = hdr_valid & ~bus.ecc_error & (ph_vc == VC_SEL);
    assign last_beat  = (remaining_reg <= BYTES_WC);

    // Byte gi is valid while more than gi bytes of the word count are outstanding.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte_en
            assign beat_byte_en[gi] = (remaining_reg > 16'(gi));
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        remaining_next    = remaining_reg;
        first_beat_next   = first_beat_reg;
        out_stream_next   = '0;
        out_byte_en_next  = '0;
        frame_valid_next  = 1'b0;
        sol_next          = 1'b0;
        eol_next          = 1'b0;
        frame_active_next = frame_active_reg;
        line_count_next   = line_count_reg;
        frame_count_next  = frame_count_reg;
        err_ecc_next      = 1'b0;
        err_trunc_next    = 1'b0;

        case (state_reg)
            PH_DECODE: begin
                if (hdr_valid && bus.ecc_error) begin
                    err_ecc_next = 1'b1;
                    state_next   = WAIT_EOT;
                end else if (hdr_accept) begin
                    if (ph_dt == DT_FS) begin
                        frame_active_next = 1'b1;
                        line_count_next   = '0;
                    end else if (ph_dt == DT_FE) begin
                        if (frame_active_reg) begin
                            frame_active_next = 1'b0;
                            frame_count_next  = frame_count_reg + FRAME_CNT_WIDTH'(1);
                        end
                    end else if (ph_dt == PX_DATA_TYPE && frame_active_reg && ph_wc != 16'd0) begin
                        remaining_next  = ph_wc;
                        first_beat_next = 1'b1;
                        state_next      = REC_DATA;
                    end else begin
                        state_next = WAIT_EOT;
                    end
                end else if (bus.valid_stream) begin
                    // Foreign VC headers and stray payload are both skipped until EoT.
                    state_next = WAIT_EOT;
                end
            end

            REC_DATA: begin
                if (bus.valid_stream) begin
                    out_stream_next  = bus.data_stream;
                    out_byte_en_next = beat_byte_en;
                    frame_valid_next = 1'b1;
                    sol_next         = first_beat_reg;
                    first_beat_next  = 1'b0;
                    remaining_next   = last_beat ? 16'd0 : remaining_reg - BYTES_WC;
                    if (last_beat) begin
                        eol_next        = 1'b1;
                        line_count_next = line_count_reg + LINE_CNT_WIDTH'(1);
                        state_next      = WAIT_EOT;
                    end
                end else begin
                    err_trunc_next  = 1'b1;
                    remaining_next  = 16'd0;
                    first_beat_next = 1'b0;
                    state_next      = PH_DECODE;
                end
            end

            WAIT_EOT: begin
                if (!bus.valid_stream) begin
                    state_next = PH_DECODE;
                end
            end

            default: state_next = PH_DECODE;
        endcase
    end

    always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
            state_reg        <= PH_DECODE;
            remaining_reg    <= '0;
            first_beat_reg   <= 1'b0;
            out_stream_reg   <= '0;
            out_byte_en_reg  <= '0;
            frame_valid_reg  <= 1'b0;
            sol_reg          <= 1'b0;
            eol_reg          <= 1'b0;
            frame_active_reg <= 1'b0;
            line_count_reg   <= '0;
            frame_count_reg  <= '0;
            err_ecc_reg      <= 1'b0;
            err_trunc_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            remaining_reg    <= remaining_next;
            first_beat_reg   <= first_beat_next;
            out_stream_reg   <= out_stream_next;
            out_byte_en_reg  <= out_byte_en_next;
            frame_valid_reg  <= frame_valid_next;
            sol_reg          <= sol_next;
            eol_reg          <= eol_next;
            frame_active_reg <= frame_active_next;
            line_count_reg   <= line_count_next;
            frame_count_reg  <= frame_count_next;
            err_ecc_reg      <= err_ecc_next;
            err_trunc_reg    <= err_trunc_next;
        end
    end

    assign bus.out_stream   = out_stream_reg;
    assign bus.out_byte_en  = out_byte_en_reg;
    assign bus.frame_valid  = frame_valid_reg;
    assign bus.sol          = sol_reg;
    assign bus.eol          = eol_reg;
    assign bus.frame_active = frame_active_reg;
    assign bus.line_count   = line_count_reg;
    assign bus.frame_count  = frame_count_reg;
    assign bus.err_ecc      = err_ecc_reg;
    assign bus.err_trunc    = err_trunc_reg;
endmodule

// File: doc/csi_pckthandler_vc.md
Name: csi_pckthandler_vc

Overview:
- Parametrised successor packet handler for the CSI-2 receive path.
- Sits after lane merging and header ECC checking, before pixel unpacking.
- Filters packets by virtual channel and configurable pixel data type, and tracks frame and line boundaries.
- Handles word counts that are not a multiple of the stream width using byte enables, and flags truncated packets and ECC-rejected headers.

Parameters:
- DATA_STREAM_WIDTH, 16, payload beat width in bits; multiple of 8; BYTES = DATA_STREAM_WIDTH/8.
- PH_STREAM_WIDTH, 24, packet header width: [23:8] WC, [7:6] VC, [5:0] DT.
- PX_DATA_TYPE, 6'h2B, accepted pixel data type (RAW10 default).
- VC_SEL, 2'd0, accepted virtual channel.
- LINE_CNT_WIDTH, 12, line counter width.
- FRAME_CNT_WIDTH, 16, frame counter width.

Ports:
- rxbyteclkhs  in  1  byte clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- data_stream  in  DATA_STREAM_WIDTH  payload beat.
- ph_stream  in  PH_STREAM_WIDTH  packet header.
- ph_select  in  1  current beat is a header.
- valid_stream  in  1  beat valid; low between packets (EoT).
- ecc_error  in  1  header has an uncorrectable ECC error.
- out_stream  out  DATA_STREAM_WIDTH  registered payload.
- out_byte_en  out  BYTES  valid bytes of out_stream; LSB = byte 0.
- frame_active  out  1  between accepted FS and FE.
- frame_valid  out  1  out_stream carries payload this cycle.
- sol  out  1  pulse coincident with the first payload beat of a line.
- eol  out  1  pulse coincident with the last payload beat of a line.
- line_count  out  LINE_CNT_WIDTH  completed lines in the current frame.
- frame_count  out  FRAME_CNT_WIDTH  accepted FE count.
- err_ecc  out  1  one-cycle pulse; header rejected for ECC.
- err_trunc  out  1  one-cycle pulse; packet ended before WC bytes.

Behaviour:
- Reset: every output is 0; state = PH_DECODE; internal remaining-byte counter = 0. Reset mid-packet aborts immediately with no error pulse.
- Header accept: valid_stream & ph_select & ~ecc_error & VC==VC_SEL.
- States:
  - PH_DECODE:
    - Accepted DT=0x00 (FS): frame_active<=1, line_count<=0, stay. FS while already active behaves the same (restart).
    - Accepted DT=0x01 (FE): if frame_active, frame_active<=0 and frame_count++ (wraps); otherwise no-op. Stay.
    - Accepted DT=PX_DATA_TYPE with frame_active and WC!=0: remaining<=WC, go to REC_DATA.
    - Accepted DT=PX_DATA_TYPE with ~frame_active or WC==0: go to WAIT_EOT.
    - Header with ecc_error (any VC): err_ecc pulse, go to WAIT_EOT.
    - VC mismatch, other DT, or valid_stream & ~ph_select: go to WAIT_EOT.
    - Otherwise stay.
  - REC_DATA (each cycle):
    - valid_stream=1: register out_stream<=data_stream and frame_valid<=1. out_byte_en = all ones if remaining>=BYTES, else the low `remaining` bits set. remaining <= remaining-BYTES, saturating at 0. sol<=1 on the first beat of the packet. If remaining<=BYTES: eol<=1, line_count++ (wraps), go to WAIT_EOT.
    - valid_stream=0 before completion: err_trunc<=1, frame_valid<=0, go to PH_DECODE. line_count is not incremented.
  - WAIT_EOT: stay while valid_stream, else go to PH_DECODE.
- Latency: header sampled at cycle N; the first payload beat is sampled at N+1 and appears on the outputs at N+2; one cycle of pipeline throughout.
- On every cycle without a payload beat: out_stream=0, out_byte_en=0, frame_valid=0, sol=0, eol=0.
- WC arithmetic is 16-bit unsigned. If BYTES >= WC, the single beat carries both sol and eol.
- Payload bytes beyond WC inside the final beat are masked by out_byte_en only; data is not zeroed.

Test Plan:
1. W=16: FS; PX header WC=6; 3 data beats 0x1111, 0x2222, 0x3333 -> frame_valid high for 3 cycles starting 2 cycles after the header. byte_en 11,11,11. sol on beat 1, eol on beat 3. line_count 0->1.
2. W=16: WC=5 -> byte_en 11,11,01; eol on beat 3. Further beats while valid are ignored (WAIT_EOT). FE -> frame_active 0, frame_count 0->1.
3. Header VC=1 with VC_SEL=0, WC=4 -> no frame_valid, line_count unchanged, return to PH_DECODE after valid_stream drops.
4. PX header with ecc_error=1 -> err_ecc single pulse, no payload output; the following clean FS is still accepted.
5. WC=8; valid_stream drops after 2 beats -> err_trunc pulse, eol never asserted, line_count unchanged; the next header is accepted.
6. Reset asserted during REC_DATA beat 2 -> the next cycle all outputs are 0, frame_active=0, counters=0; PX header without FS goes to WAIT_EOT with no output.
